mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Parametrised, multi-cycle multiply/divide unit for the npc execute stage.
- Replaces the single-cycle `*`, `/` and `%` operators in the combinational ALU.
- Supports the full RV64M op set, including W variants.
- Uses valid/ready handshakes on input and output, so the pipeline stalls while it is busy.
- Uses one shift-add or restoring-division step per cycle.

Parameters:
- XLEN, 64, operand/result width (32 or 64; W ops exist only when XLEN=64).
- OPW, 4, width of op field.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  abort any in-flight op (pipeline redirect).
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- op  in  OPW  operation code (below).
- src1  in  XLEN  operand 1 (multiplicand / dividend).
- src2  in  XLEN  operand 2 (multiplier / divisor).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  result.

Behaviour:
- Op codes:
  - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 MULW.
  - 8 DIV, 9 DIVU, 10 REM, 11 REMU.
  - 12 DIVW, 13 DIVUW, 14 REMW, 15 REMUW.
  - Codes 5-7: result 0, one-cycle latency.
- Reset: state IDLE; in_ready=1, out_valid=0, result=0; all internal registers cleared.
- States:
  - IDLE: in_ready=1. On in_valid, latch op/operands and go to CALC, or to DONE for early-out cases.
  - CALC: in_ready=0. Decrement the step counter each cycle; at counter==0 go to DONE.
  - DONE: out_valid=1, result held stable. When out_ready=1, go to IDLE.
- Latency (accept at cycle T):
  - out_valid rises at T+1+N.
  - N = XLEN for full-width ops; N = 32 for W ops.
  - N = 0 for early-out cases.
- No back-to-back overlap: in_ready stays 0 from the accept cycle through the out_valid&out_ready cycle. in_ready is registered, not combinationally dependent on out_ready.
- Operand preparation at accept:
  - Signed ops take magnitudes and record result and remainder signs.
  - W ops use src[31:0], sign- or zero-extended per op.
- Multiply:
  - Unsigned 2*XLEN product accumulator, one multiplier bit per step.
  - Final negate if sign set.
  - MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2*XLEN-1:XLEN].
  - MULW returns the sign-extended product[31:0].
- Divide:
  - Restoring, one quotient bit per step; remainder register is XLEN+1 bits.
  - Final sign fix-up: quotient sign = s1^s2; remainder sign = s1.
- Early-out cases (DONE the next cycle, no CALC):
  - Divisor==0: quotient = all ones (W ops: sign-extended 0xFFFFFFFF); remainder = dividend (W ops: sign-extended src1[31:0]).
  - Signed overflow (dividend = most-negative, divisor = -1): quotient = dividend; remainder = 0. For W ops this applies to the 32-bit values.
- W results are always sign-extended from bit 31, including DIVUW and REMUW.
- flush:
  - Any state goes to IDLE next cycle, out_valid=0, and the result is discarded.
  - flush together with in_valid in IDLE: the request is not accepted.
  - flush has priority over out_ready.
- rst mid-operation: identical to the reset state next cycle; no result is produced.
- Held out_valid: result and out_valid stay constant while out_ready=0. in_valid is ignored meanwhile.

Optional Feature:
- Macro: MDU_FAST_MUL_EN.
- Defined: multiply ops (0-4) use a single combinational 2*XLEN signed/unsigned product registered at accept, so N=0 (out_valid at T+1). Divide timing is unchanged.
- Undefined: all multiplies are iterative with N per the latency rule above.

Test Plan:
- MULH src1=0x8000000000000000, src2=0x8000000000000000 -> result 0x4000000000000000; out_valid exactly 65 cycles after accept (1 cycle with MDU_FAST_MUL_EN).
- DIV src1=-7, src2=2 -> result -3 (0xFFFFFFFFFFFFFFFD); REM same operands -> result -1.
- DIVU src1=100, src2=0 -> result 0xFFFFFFFFFFFFFFFF in 1 cycle; REMU same operands -> result 100.
- DIVW src1=0x0000000080000000, src2=0xFFFFFFFFFFFFFFFF -> result 0xFFFFFFFF80000000; REMW same operands -> result 0.
- MULW src1=0x7FFFFFFF, src2=2 -> result 0xFFFFFFFFFFFFFFFE, latency 33; hold out_ready=0 for 5 cycles -> result stable, in_ready=0.
- Start DIVU 1000/7, assert flush at step 10 -> out_valid never rises, in_ready=1 next cycle; a new DIVU 1000/7 then returns 142.

Source files
------------

// File: rtl/mdu_iter_if.sv
// Request/response handshake bundle for the iterative multiply/divide unit.
// master = requesting pipeline stage, slave = mdu_iter.
interface mdu_iter_if #(
  parameter int XLEN = 64,
  parameter int OPW  = 4
);
  logic            in_valid;
  logic            in_ready;
  logic [OPW-1:0]  op;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output in_valid, op, src1, src2, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, op, src1, src2, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/mdu_iter.sv
// Multi-cycle RV64M multiply/divide unit: one shift-add or restoring-divide step per cycle.
// Optional macro MDU_FAST_MUL_EN: multiplies complete with a single-cycle product at accept.
module mdu_iter #(
  parameter int XLEN = 64,
  parameter int OPW  = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  mdu_iter_if.slave bus
);

  localparam int CW  = $clog2(XLEN);
  localparam int WSH = XLEN - 32;

  localparam logic [OPW-1:0] OP_MUL    = OPW'(0);
  localparam logic [OPW-1:0] OP_MULH   = OPW'(1);
  localparam logic [OPW-1:0] OP_MULHSU = OPW'(2);
  localparam logic [OPW-1:0] OP_MULHU  = OPW'(3);
  localparam logic [OPW-1:0] OP_MULW   = OPW'(4);
  localparam logic [OPW-1:0] OP_DIV    = OPW'(8);
  localparam logic [OPW-1:0] OP_DIVU   = OPW'(9);
  localparam logic [OPW-1:0] OP_REM    = OPW'(10);
  localparam logic [OPW-1:0] OP_REMU   = OPW'(11);
  localparam logic [OPW-1:0] OP_DIVW   = OPW'(12);
  localparam logic [OPW-1:0] OP_DIVUW  = OPW'(13);
  localparam logic [OPW-1:0] OP_REMW   = OPW'(14);
  localparam logic [OPW-1:0] OP_REMUW  = OPW'(15);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [OPW-1:0]    op_q, op_d;
  logic              sgn_res_q, sgn_res_d;
  logic              sgn_rem_q, sgn_rem_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  logic              dec_mul, dec_div, dec_rem, dec_w, dec_s1, dec_s2;
  logic [XLEN-1:0]   a_ext, b_ext, mag1, mag2, sx1;
  logic              s1, s2, div_zero, div_ovf;

  logic [2*XLEN-1:0] acc_step;
  logic [XLEN+1:0]   r_shift, r_sub;
  logic [XLEN:0]     rem_step;
  logic [XLEN-1:0]   quo_step;
  logic              ge;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  // Applies the recorded signs to the unsigned magnitudes and picks the op's result field.
  function automatic logic [XLEN-1:0] finalize(
    input logic [OPW-1:0]    f_op,
    input logic [2*XLEN-1:0] prod_mag,
    input logic [XLEN-1:0]   quo_mag,
    input logic [XLEN-1:0]   rem_mag,
    input logic              neg_res,
    input logic              neg_rem
  );
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   res;
    prod = neg_res ? -prod_mag : prod_mag;
    quo  = neg_res ? -quo_mag  : quo_mag;
    rem  = neg_rem ? -rem_mag  : rem_mag;
    case (f_op)
      OP_MUL:                       res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res = prod[2*XLEN-1:XLEN];
      OP_MULW:                      res = sext32(prod[31:0]);
      OP_DIV, OP_DIVU:              res = quo;
      OP_REM, OP_REMU:              res = rem;
      OP_DIVW, OP_DIVUW:            res = sext32(quo[31:0]);
      OP_REMW, OP_REMUW:            res = sext32(rem[31:0]);
      default:                      res = {XLEN{1'b0}};
    endcase
    return res;
  endfunction

  // Classify the incoming op and prepare unsigned magnitudes plus early-out conditions.
  always_comb begin
    dec_mul = 1'b0;
    dec_div = 1'b0;
    dec_rem = 1'b0;
    dec_w   = 1'b0;
    dec_s1  = 1'b0;
    dec_s2  = 1'b0;
    case (bus.op)
      OP_MUL, OP_MULHU:   dec_mul = 1'b1;
      OP_MULH:            begin dec_mul = 1'b1; dec_s1 = 1'b1; dec_s2 = 1'b1; end
      OP_MULHSU:          begin dec_mul = 1'b1; dec_s1 = 1'b1; end
      OP_MULW:            begin dec_mul = 1'b1; dec_w = 1'b1; end
      OP_DIV:             begin dec_div = 1'b1; dec_s1 = 1'b1; dec_s2 = 1'b1; end
      OP_DIVU:            dec_div = 1'b1;
      OP_REM:             begin dec_div = 1'b1; dec_rem = 1'b1; dec_s1 = 1'b1; dec_s2 = 1'b1; end
      OP_REMU:            begin dec_div = 1'b1; dec_rem = 1'b1; end
      OP_DIVW:            begin dec_div = 1'b1; dec_w = 1'b1; dec_s1 = 1'b1; dec_s2 = 1'b1; end
      OP_DIVUW:           begin dec_div = 1'b1; dec_w = 1'b1; end
      OP_REMW:            begin dec_div = 1'b1; dec_w = 1'b1; dec_rem = 1'b1; dec_s1 = 1'b1; dec_s2 = 1'b1; end
      OP_REMUW:           begin dec_div = 1'b1; dec_w = 1'b1; dec_rem = 1'b1; end
      default:            dec_mul = 1'b0;
    endcase

    sx1 = sext32(bus.src1[31:0]);
    if (dec_w) begin
      a_ext = dec_s1 ? sx1 : XLEN'(bus.src1[31:0]);
      b_ext = dec_s2 ? sext32(bus.src2[31:0]) : XLEN'(bus.src2[31:0]);
    end else begin
      a_ext = bus.src1;
      b_ext = bus.src2;
    end

    s1   = dec_s1 & a_ext[XLEN-1];
    s2   = dec_s2 & b_ext[XLEN-1];
    mag1 = s1 ? -a_ext : a_ext;
    mag2 = s2 ? -b_ext : b_ext;

    div_zero = (b_ext == {XLEN{1'b0}});
    if (dec_w) begin
      div_ovf = dec_s1 & (bus.src1[31:0] == 32'h8000_0000) & (bus.src2[31:0] == 32'hFFFF_FFFF);
    end else begin
      div_ovf = dec_s1 & (bus.src1 == {1'b1, {(XLEN-1){1'b0}}}) & (bus.src2 == {XLEN{1'b1}});
    end
  end

  // One shift-add multiply step and one restoring-divide step from the current registers.
  always_comb begin
    if (mplier_q[0]) begin
      acc_step = acc_q + mcand_q;
    end else begin
      acc_step = acc_q;
    end
    r_shift  = {rem_q, quo_q[XLEN-1]};
    r_sub    = r_shift - {2'b00, dvs_q};
    ge       = ~r_sub[XLEN+1];
    rem_step = ge ? r_sub[XLEN:0] : r_shift[XLEN:0];
    quo_step = {quo_q[XLEN-2:0], ge};
  end

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = (2*XLEN)'(mag1) * (2*XLEN)'(mag2);
`endif

  // Next-state and datapath update; flush overrides everything and drops the request/result.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    sgn_res_d = sgn_res_q;
    sgn_rem_d = sgn_rem_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    result_d  = result_q;

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            op_d      = bus.op;
            sgn_res_d = s1 ^ s2;
            sgn_rem_d = s1;
            acc_d     = {(2*XLEN){1'b0}};
            mcand_d   = (2*XLEN)'(mag1);
            mplier_d  = mag2;
            rem_d     = {(XLEN+1){1'b0}};
            quo_d     = dec_w ? (mag1 << WSH) : mag1;
            dvs_d     = mag2;
            cnt_d     = dec_w ? CW'(31) : CW'(XLEN - 1);
            if (!dec_mul && !dec_div) begin
              result_d = {XLEN{1'b0}};
              state_d  = S_DONE;
            end else if (dec_div && div_zero) begin
              result_d = dec_rem ? (dec_w ? sx1 : bus.src1) : {XLEN{1'b1}};
              state_d  = S_DONE;
            end else if (dec_div && div_ovf) begin
              result_d = dec_rem ? {XLEN{1'b0}} : (dec_w ? sx1 : bus.src1);
              state_d  = S_DONE;
            end else begin
`ifdef MDU_FAST_MUL_EN
              if (dec_mul) begin
                result_d = finalize(bus.op, fast_prod, {XLEN{1'b0}}, {XLEN{1'b0}}, s1 ^ s2, 1'b0);
                state_d  = S_DONE;
              end else begin
                state_d = S_CALC;
              end
`else
              state_d = S_CALC;
`endif
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CALC: begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          rem_d    = rem_step;
          quo_d    = quo_step;
          if (cnt_q == {CW{1'b0}}) begin
            result_d = finalize(op_q, acc_step, quo_step, rem_step[XLEN-1:0], sgn_res_q, sgn_rem_q);
            state_d  = S_DONE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  // State and datapath registers, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CW{1'b0}};
      op_q        <= {OPW{1'b0}};
      sgn_res_q   <= 1'b0;
      sgn_rem_q   <= 1'b0;
      acc_q       <= {(2*XLEN){1'b0}};
      mcand_q     <= {(2*XLEN){1'b0}};
      mplier_q    <= {XLEN{1'b0}};
      quo_q       <= {XLEN{1'b0}};
      dvs_q       <= {XLEN{1'b0}};
      rem_q       <= {(XLEN+1){1'b0}};
      result_q    <= {XLEN{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      sgn_res_q   <= sgn_res_d;
      sgn_rem_q   <= sgn_rem_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Randomised self-checking bench for mdu_iter against a plain-arithmetic RV64M reference.
module tb_mdu_iter;
  localparam int XLEN = 64;
  localparam int OPW  = 4;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  mdu_iter_if #(.XLEN(XLEN), .OPW(OPW)) bus ();

  mdu_iter #(.XLEN(XLEN), .OPW(OPW)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Architectural RV64M result, straight from the ISA rules.
  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] pa, pb, p;
    logic signed [63:0] sa, sb;
    logic signed [31:0] wa, wb;
    logic [31:0] ua, ub, t;
    sa = a; sb = b; wa = a[31:0]; wb = b[31:0]; ua = a[31:0]; ub = b[31:0];
    case (op)
      4'd0: return a * b;
      4'd1: begin pa = {{64{a[63]}}, a}; pb = {{64{b[63]}}, b}; p = pa * pb; return p[127:64]; end
      4'd2: begin pa = {{64{a[63]}}, a}; pb = {64'd0, b};       p = pa * pb; return p[127:64]; end
      4'd3: begin pa = {64'd0, a};       pb = {64'd0, b};       p = pa * pb; return p[127:64]; end
      4'd4: begin t = ua * ub; return sx(t); end
      4'd8: begin
        if (b == 64'd0) return ONES;
        if (a == MIN64 && b == ONES) return a;
        return sa / sb;
      end
      4'd9:  return (b == 64'd0) ? ONES : a / b;
      4'd10: begin
        if (b == 64'd0) return a;
        if (a == MIN64 && b == ONES) return 64'd0;
        return sa % sb;
      end
      4'd11: return (b == 64'd0) ? a : a % b;
      4'd12: begin
        if (ub == 32'd0) return ONES;
        if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) return sx(ua);
        t = wa / wb; return sx(t);
      end
      4'd13: begin
        if (ub == 32'd0) return ONES;
        t = ua / ub; return sx(t);
      end
      4'd14: begin
        if (ub == 32'd0) return sx(ua);
        if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) return 64'd0;
        t = wa % wb; return sx(t);
      end
      4'd15: begin
        if (ub == 32'd0) return sx(ua);
        t = ua % ub; return sx(t);
      end
      default: return 64'd0;
    endcase
  endfunction

  // Edges from accept (inclusive) until out_valid is visible.
  function automatic int ref_latency(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    bit w, zero, sgn, ovf;
    if (op >= 4'd5 && op <= 4'd7) return 1;
    if (op >= 4'd8) begin
      w    = (op >= 4'd12);
      sgn  = (op == 4'd8) || (op == 4'd10) || (op == 4'd12) || (op == 4'd14);
      zero = w ? (b[31:0] == 32'd0) : (b == 64'd0);
      ovf  = sgn && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                       : (a == MIN64 && b == ONES));
      if (zero || ovf) return 1;
      return w ? 33 : 65;
    end
`ifdef MDU_FAST_MUL_EN
    return 1;
`else
    return (op == 4'd4) ? 33 : 65;
`endif
  endfunction

  function automatic logic [63:0] pick();
    logic [31:0] t;
    t = $urandom;
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return ONES;
      2: return MIN64;
      3: return 64'h0000_0000_8000_0000;
      4: return 64'($urandom_range(0, 20));
      5: return {{32{t[31]}}, t};
      default: return {$urandom, t};
    endcase
  endfunction

  // Issue one request, check latency/result, hold the result for `hold` cycles, then consume.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input int hold);
    int lat;
    bit seen;
    bit bad;
    logic [63:0] held;
    @(negedge clk);
    check_val({tag, "/ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1; bus.op = op; bus.src1 = a; bus.src2 = b;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 200) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.op = 4'($urandom); bus.src1 = {$urandom, $urandom}; bus.src2 = {$urandom, $urandom};
      lat++;
      if (lat == 1) check_val({tag, "/busy"}, 64'(bus.in_ready), 64'd0);
      seen = bus.out_valid;
    end
    check_val({tag, "/lat"}, 64'(lat), 64'(ref_latency(op, a, b)));
    check_val({tag, "/res"}, bus.result, exp);
    held = bus.result; bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      @(negedge clk);
      if (bus.result !== held || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bad = 1'b1;
    end
    if (hold > 0) check_val({tag, "/hold"}, 64'(bad), 64'd0);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_val({tag, "/release"}, {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
  endtask

  initial begin
    bit seen;
    logic [3:0]  op;
    logic [63:0] a, b;
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = 4'd0; bus.src1 = 64'd0; bus.src2 = 64'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("reset", {bus.in_ready, bus.out_valid, 62'd0}, {1'b1, 1'b0, 62'd0});
    check_val("reset/res", bus.result, 64'd0);

    run_op("mulh_min", 4'd1, MIN64, MIN64, 64'h4000_0000_0000_0000, 0);
    run_op("div_neg", 4'd8, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    run_op("rem_neg", 4'd10, -64'sd7, 64'd2, ONES, 0);
    run_op("divu_z", 4'd9, 64'd100, 64'd0, ONES, 0);
    run_op("remu_z", 4'd11, 64'd100, 64'd0, 64'd100, 0);
    run_op("divw_ovf", 4'd12, 64'h0000_0000_8000_0000, ONES, 64'hFFFF_FFFF_8000_0000, 0);
    run_op("remw_ovf", 4'd14, 64'h0000_0000_8000_0000, ONES, 64'd0, 0);
    run_op("mulw", 4'd4, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 5);
    run_op("op6", 4'd6, 64'd123, 64'd45, 64'd0, 1);
    run_op("mulhsu", 4'd2, ONES, 64'd2, ONES, 0);
    run_op("divuw", 4'd13, 64'h1234_5678_FFFF_FFFF, 64'd1, ONES, 0);

    // Flush mid-divide: nothing may come out, and a fresh request works afterwards.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = 4'd9; bus.src1 = 64'd1000; bus.src2 = 64'd7;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_val("flush/state", {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
    seen = 1'b0;
    repeat (80) begin @(negedge clk); seen |= bus.out_valid; end
    check_val("flush/noval", 64'(seen), 64'd0);
    run_op("divu_post", 4'd9, 64'd1000, 64'd7, 64'd142, 0);

    // Flush alongside a request in IDLE: the request must be dropped.
    @(negedge clk);
    bus.in_valid = 1'b1; flush = 1'b1; bus.op = 4'd9; bus.src1 = 64'd5; bus.src2 = 64'd0;
    @(negedge clk);
    bus.in_valid = 1'b0; flush = 1'b0;
    check_val("flush_req", {62'd0, bus.out_valid, bus.in_ready}, 64'd1);

    // Reset mid-operation.
    bus.in_valid = 1'b1; bus.op = 4'd8; bus.src1 = 64'd999; bus.src2 = 64'd3;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("rst_mid", {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
    check_val("rst_mid/res", bus.result, 64'd0);
    seen = 1'b0;
    repeat (70) begin @(negedge clk); seen |= bus.out_valid; end
    check_val("rst_mid/noval", 64'(seen), 64'd0);

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = pick();
      b  = pick();
      run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, ref_result(op, a, b), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
